// File: rtl/spi_cmd_parser_if.sv
// Bundle of signals between the SPI byte receiver, the command parser,
// sprite memory and the sprite renderer.
interface spi_cmd_parser_if #(
  parameter int SPRITE_PIXELS = 512,
  parameter int ID_W          = 4
);
  localparam int PIX_W = $clog2(SPRITE_PIXELS);

  logic                    cs_active;
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    mem_we;
  logic [ID_W+PIX_W-1:0]   mem_addr;
  logic [7:0]              mem_wdata;
  logic                    draw_valid;
  logic                    draw_ready;
  logic [ID_W-1:0]         draw_id;
  logic [15:0]             draw_x;
  logic [15:0]             draw_y;
  logic [7:0]              draw_scale;
  logic                    err_frame;
  logic                    err_opcode;
  logic                    err_overflow;
  logic                    busy;
  logic [7:0]              cmd_count;

  modport master (
    output cs_active, rx_data, rx_valid, draw_ready,
    input  mem_we, mem_addr, mem_wdata, draw_valid, draw_id, draw_x, draw_y,
           draw_scale, err_frame, err_opcode, err_overflow, busy, cmd_count
  );

  modport slave (
    input  cs_active, rx_data, rx_valid, draw_ready,
    output mem_we, mem_addr, mem_wdata, draw_valid, draw_id, draw_x, draw_y,
           draw_scale, err_frame, err_opcode, err_overflow, busy, cmd_count
  );
endinterface

// File: rtl/spi_cmd_parser.sv
// Decodes SPRITE_LOAD / DRAW commands from the SPI byte stream into sprite
// memory writes and a single-entry draw request holding register.
module spi_cmd_parser #(
  parameter int SPRITE_PIXELS = 512,
  parameter int ID_W          = 4
) (
  input logic               sys_clock,
  input logic               sys_reset_n,
  spi_cmd_parser_if.slave   bus
);
  localparam int PIX_W = $clog2(SPRITE_PIXELS);
  localparam int AW    = ID_W + PIX_W;
  localparam logic [7:0]       OP_LOAD  = 8'h00;
  localparam logic [7:0]       OP_DRAW  = 8'h01;
  localparam logic [7:0]       END_BYTE = 8'h00;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(SPRITE_PIXELS - 1);
  localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_PIX, S_XH, S_XL, S_YH, S_YL, S_SCALE, S_END, S_DISCARD
  } state_e;

  state_e            state_q, state_d;
  logic              isDraw_q, isDraw_d;
  logic [PIX_W-1:0]  pixelIndex_q, pixelIndex_d;
  logic [ID_W-1:0]   spriteId_q, spriteId_d;
  logic [15:0]       xField_q, xField_d;
  logic [15:0]       yField_q, yField_d;
  logic [7:0]        scaleField_q, scaleField_d;
  logic              memWe_q, memWe_d;
  logic [AW-1:0]     memAddr_q, memAddr_d;
  logic [7:0]        memWdata_q, memWdata_d;
  logic              drawValid_q, drawValid_d;
  logic [ID_W-1:0]   drawId_q, drawId_d;
  logic [15:0]       drawX_q, drawX_d;
  logic [15:0]       drawY_q, drawY_d;
  logic [7:0]        drawScale_q, drawScale_d;
  logic              errFrame_q, errFrame_d;
  logic              errOpcode_q, errOpcode_d;
  logic              errOverflow_q, errOverflow_d;
  logic              busy_q, busy_d;
  logic [7:0]        cmdCount_q, cmdCount_d;
  logic              drawDone;

  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q       <= S_IDLE;
      isDraw_q      <= 1'b0;
      pixelIndex_q  <= '0;
      spriteId_q    <= '0;
      xField_q      <= '0;
      yField_q      <= '0;
      scaleField_q  <= '0;
      memWe_q       <= 1'b0;
      memAddr_q     <= '0;
      memWdata_q    <= '0;
      drawValid_q   <= 1'b0;
      drawId_q      <= '0;
      drawX_q       <= '0;
      drawY_q       <= '0;
      drawScale_q   <= '0;
      errFrame_q    <= 1'b0;
      errOpcode_q   <= 1'b0;
      errOverflow_q <= 1'b0;
      busy_q        <= 1'b0;
      cmdCount_q    <= '0;
    end else begin
      state_q       <= state_d;
      isDraw_q      <= isDraw_d;
      pixelIndex_q  <= pixelIndex_d;
      spriteId_q    <= spriteId_d;
      xField_q      <= xField_d;
      yField_q      <= yField_d;
      scaleField_q  <= scaleField_d;
      memWe_q       <= memWe_d;
      memAddr_q     <= memAddr_d;
      memWdata_q    <= memWdata_d;
      drawValid_q   <= drawValid_d;
      drawId_q      <= drawId_d;
      drawX_q       <= drawX_d;
      drawY_q       <= drawY_d;
      drawScale_q   <= drawScale_d;
      errFrame_q    <= errFrame_d;
      errOpcode_q   <= errOpcode_d;
      errOverflow_q <= errOverflow_d;
      busy_q        <= busy_d;
      cmdCount_q    <= cmdCount_d;
    end
  end

  // A dropped chip select overrides any byte arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    if (!bus.cs_active) begin
      state_d = S_IDLE;
    end else if (bus.rx_valid) begin
      case (state_q)
        S_IDLE:    state_d = (bus.rx_data == OP_LOAD || bus.rx_data == OP_DRAW)
                             ? S_ID : S_DISCARD;
        S_ID:      state_d = isDraw_q ? S_XH : S_PIX;
        S_PIX:     state_d = (pixelIndex_q == PIX_LAST) ? S_END : S_PIX;
        S_XH:      state_d = S_XL;
        S_XL:      state_d = S_YH;
        S_YH:      state_d = S_YL;
        S_YL:      state_d = S_SCALE;
        S_SCALE:   state_d = S_END;
        S_END:     state_d = S_IDLE;
        S_DISCARD: state_d = S_DISCARD;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    isDraw_d      = isDraw_q;
    pixelIndex_d  = pixelIndex_q;
    spriteId_d    = spriteId_q;
    xField_d      = xField_q;
    yField_d      = yField_q;
    scaleField_d  = scaleField_q;
    memWe_d       = 1'b0;
    memAddr_d     = memAddr_q;
    memWdata_d    = memWdata_q;
    drawValid_d   = drawValid_q;
    drawId_d      = drawId_q;
    drawX_d       = drawX_q;
    drawY_d       = drawY_q;
    drawScale_d   = drawScale_q;
    errFrame_d    = 1'b0;
    errOpcode_d   = 1'b0;
    errOverflow_d = 1'b0;
    cmdCount_d    = cmdCount_q;
    drawDone      = 1'b0;

    if (!bus.cs_active) begin
      pixelIndex_d = '0;
      errFrame_d   = (state_q != S_IDLE) && (state_q != S_DISCARD);
    end else if (bus.rx_valid) begin
      case (state_q)
        S_IDLE: begin
          isDraw_d    = (bus.rx_data == OP_DRAW);
          errOpcode_d = (bus.rx_data != OP_LOAD) && (bus.rx_data != OP_DRAW);
        end
        S_ID:    spriteId_d = bus.rx_data[ID_W-1:0];
        S_PIX: begin
          memWe_d      = 1'b1;
          memAddr_d    = {spriteId_q, pixelIndex_q};
          memWdata_d   = bus.rx_data;
          pixelIndex_d = pixelIndex_q + PIX_ONE;
        end
        S_XH:    xField_d[15:8]  = bus.rx_data;
        S_XL:    xField_d[7:0]   = bus.rx_data;
        S_YH:    yField_d[15:8]  = bus.rx_data;
        S_YL:    yField_d[7:0]   = bus.rx_data;
        S_SCALE: scaleField_d    = bus.rx_data;
        S_END: begin
          if (bus.rx_data == END_BYTE) begin
            cmdCount_d = cmdCount_q + 8'd1;
            drawDone   = isDraw_q;
          end else begin
            errFrame_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A same-cycle handshake frees the holding register for the new request.
    if (drawDone) begin
      if (!drawValid_q || bus.draw_ready) begin
        drawValid_d = 1'b1;
        drawId_d    = spriteId_q;
        drawX_d     = xField_q;
        drawY_d     = yField_q;
        drawScale_d = scaleField_q;
      end else begin
        errOverflow_d = 1'b1;
      end
    end else if (drawValid_q && bus.draw_ready) begin
      drawValid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.mem_we       = memWe_q;
  assign bus.mem_addr     = memAddr_q;
  assign bus.mem_wdata    = memWdata_q;
  assign bus.draw_valid   = drawValid_q;
  assign bus.draw_id      = drawId_q;
  assign bus.draw_x       = drawX_q;
  assign bus.draw_y       = drawY_q;
  assign bus.draw_scale   = drawScale_q;
  assign bus.err_frame    = errFrame_q;
  assign bus.err_opcode   = errOpcode_q;
  assign bus.err_overflow = errOverflow_q;
  assign bus.busy         = busy_q;
  assign bus.cmd_count    = cmdCount_q;
endmodule
